// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the simple processor: fetch, register moves and
// three-step ALU operations over the shared bus, plus a retired-instruction counter.
module multicycle_control_unit #(
    parameter int NUM_REGS = 8,
    parameter int INSTR_W  = 16,
    parameter int COUNT_W  = 16,
    localparam int RW      = $clog2(NUM_REGS),
    localparam int MW      = $clog2(NUM_REGS + 2)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [INSTR_W-1:0]  instruction,
    output logic                en_inst,
    output logic [NUM_REGS-1:0] reg_en,
    output logic [MW-1:0]       mux_sel,
    output logic                en_a,
    output logic                en_g,
    output logic [3:0]          alu_sel,
    output logic                done,
    output logic                illegal,
    output logic [COUNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_MV  = 4'd0,
        OP_MVI = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6
    } opcode_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    opcode;
    logic [RW-1:0] rx;
    logic [RW-1:0] ry;
    logic          is_alu_op;

    assign opcode    = instruction[INSTR_W-1 -: 4];
    assign rx        = instruction[INSTR_W-5 -: RW];
    assign ry        = instruction[INSTR_W-5-RW -: RW];
    assign is_alu_op = (opcode >= OP_ADD) && (opcode <= OP_XOR);

    // Bits below Ry carry no meaning for the control unit.
    generate
        if (INSTR_W > 4 + 2 * RW) begin : g_spare_bits
            logic unused_low_bits;
            assign unused_low_bits = ^instruction[INSTR_W-5-2*RW:0];
        end
    endgenerate

    // Outputs decode straight from state so an asynchronous reset drops every
    // enable in the same cycle, before any partial write can complete.
    always_comb begin
        // NOTE: every output gets a default first; otherwise paths that skip an
        // assignment would infer latches.
        state_next = state;
        en_inst    = 1'b0;
        reg_en     = '0;
        mux_sel    = '0;
        en_a       = 1'b0;
        en_g       = 1'b0;
        alu_sel    = 4'd0;
        done       = 1'b0;
        illegal    = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    en_inst    = 1'b1;
                    state_next = T1;
                end
            end
            T1: begin
                if (opcode == OP_MV) begin
                    mux_sel    = MW'(ry);
                    reg_en[rx] = 1'b1;
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (opcode == OP_MVI) begin
                    mux_sel    = MW'(NUM_REGS + 1);
                    reg_en[rx] = 1'b1;
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (is_alu_op) begin
                    mux_sel    = MW'(rx);
                    en_a       = 1'b1;
                    state_next = T2;
                end else begin
                    illegal    = 1'b1;
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            T2: begin
                mux_sel    = MW'(ry);
                alu_sel    = opcode;
                en_g       = 1'b1;
                state_next = T3;
            end
            T3: begin
                mux_sel    = MW'(NUM_REGS);
                reg_en[rx] = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter wraps naturally at its width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state       <= IDLE;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (done) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle control FSM for the lab simple processor. It sequences instruction fetch, operand movement and ALU operations over the shared bus. It drives register-file load enables, the bus source select, the A/G/IR loads, the ALU op select and a done strobe. It also keeps a wrapping count of retired instructions. It generalises the fixed 8-register, 3-state control unit to a configurable register count, a wider instruction set, illegal-opcode detection and a retired-instruction counter.

## Interface
Parameters:
- NUM_REGS, 8, number of GPRs; power of 2, 2..16. RW = log2(NUM_REGS).
- INSTR_W, 16, instruction width; must be >= 4 + 2*RW.
- COUNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; one clock domain only.
- run  in  1  start request; sampled only in IDLE.
- instruction  in  INSTR_W  output of the external IR; valid from the cycle after en_inst.
- en_inst  out  1  IR load.
- reg_en  out  NUM_REGS  one-hot GPR load; bit k loads Rk from the bus.
- mux_sel  out  log2(NUM_REGS+2), rounded up  bus source: 0..NUM_REGS-1 = Rk, NUM_REGS = G, NUM_REGS+1 = DIN.
- en_a  out  1  load the A register from the bus.
- en_g  out  1  load the G register from the ALU.
- alu_sel  out  4  ALU op; equals the opcode in T2, 0 otherwise.
- done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  one-cycle pulse when an undefined opcode executes.
- instr_count  out  COUNT_W  instructions retired, including illegal ones.

## Operation
- Instruction fields:
  - opcode = instruction[INSTR_W-1 -: 4]
  - Rx = next RW bits below the opcode
  - Ry = next RW bits below Rx
  - all lower bits ignored
- Opcodes:
  - 0 MV: Rx<-Ry
  - 1 MVI: Rx<-DIN
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: Rx<-Rx op Ry
  - 7..15 illegal
- States are IDLE, T1, T2, T3. Outputs are a combinational decode of state plus instruction; unlisted outputs are 0.
- IDLE:
  - run=1: en_inst=1, go to T1.
  - run=0: stay in IDLE, all outputs 0.
- T1 behaviour by opcode:
  - MV: mux_sel=Ry, reg_en[Rx]=1, done=1, go to IDLE.
  - MVI: mux_sel=NUM_REGS+1, reg_en[Rx]=1, done=1, go to IDLE. The immediate must be on DIN during T1.
  - ALU ops: mux_sel=Rx, en_a=1, go to T2.
  - Illegal: illegal=1, done=1, no loads, go to IDLE.
- T2 (ALU ops): mux_sel=Ry, alu_sel=opcode, en_g=1, go to T3.
- T3 (ALU ops): mux_sel=NUM_REGS, reg_en[Rx]=1, done=1, go to IDLE.
- instr_count increments by 1 on every clock edge where done=1. It wraps from 2^COUNT_W-1 to 0.
- Rx == Ry is legal:
  - MV Rx,Rx rewrites the same value.
  - SUB Rx,Rx yields 0.
- run is ignored outside IDLE; holding run high does not stall or restart an instruction.

## Timing
- Reset values:
  - state = IDLE
  - instr_count = 0
  - every output is 0, because decode from IDLE with run=0 gives all zero
- Reset asserted mid-instruction forces IDLE immediately, without waiting for a clock edge. All enables drop in the same cycle; no partial write completes afterward. instr_count clears.
- Latency from the run-accepted cycle to done, inclusive:
  - MV, MVI, illegal: 2 cycles
  - ALU ops: 4 cycles
- Back-to-back: the cycle after done is IDLE. If run=1 there, the next fetch happens then, so there is exactly one fetch cycle between instructions.
- reg_en is never multi-hot. At most one of en_inst, en_a, en_g, or any reg_en bit is asserted in a cycle.

## Test plan
- Reset then idle: assert reset with run=1, release, hold run=0 for 5 cycles -> all outputs 0, instr_count=0, no en_inst.
- MV R3,R5 (0x0740), NUM_REGS=8:
  - run pulse -> en_inst in cycle 0.
  - Cycle 1: mux_sel=5, reg_en=8'b0000_1000, done=1.
  - instr_count=1 afterward.
- ADD R1,R2 (0x2280):
  - T1: mux_sel=1, en_a=1.
  - T2: mux_sel=2, alu_sel=2, en_g=1.
  - T3: mux_sel=8, reg_en=8'b0000_0010, done=1.
  - Repeat with SUB (0x3280) -> alu_sel=3 in T2.
- MVI R7 (0x1E00) then illegal 0xF000 back-to-back with run held high:
  - MVI T1: mux_sel=9, reg_en=8'h80, done=1.
  - Next cycle: en_inst.
  - Following cycle: illegal=1, done=1, reg_en=0.
  - instr_count advances by 2.
- Reset mid-ALU: assert reset asynchronously during T2 of XOR R0,R4 (0x6100) -> en_g and alu_sel drop to 0 immediately. No reg_en pulse follows; state IDLE; instr_count=0.
- Counter wrap with COUNT_W=3: retire 9 MV instructions -> instr_count sequence 1..7, 0, 1.
